eco_bist_ctrl: RTL
==================

# eco_bist_ctrl

Self-test controller for the small gate-level ECO test circuits: two 5-bit operands in, one 3-bit result out, purely combinational.
- Drives the circuit's `A`/`B` inputs from an internal LFSR pattern generator.
- Reads back the `Y` result every cycle and compacts it into a MISR signature.
- Compares the final signature against a golden value, so a pre-ECO and a post-ECO netlist can be checked for equivalence in simulation or on silicon.

## Interface
Parameters:
- `SEED` — default 10'h001 — LFSR load value on start; must be nonzero.
- `N_PAT` — default 1023 — patterns applied per run, legal range 1..1023.
- `GOLDEN` — default 16'h0000 — expected final signature.

Ports:
- `clk` — in — 1 — single clock, rising edge.
- `rst` — in — 1 — synchronous, active-high reset.
- `start` — in — 1 — run request, sampled only in IDLE or DONE.
- `a_out` — out — 5 — drives the circuit's `A`; equals lfsr[4:0].
- `b_out` — out — 5 — drives the circuit's `B`; equals lfsr[9:5].
- `y_in` — in — 3 — circuit's `Y`, combinational response to `a_out`/`b_out`.
- `busy` — out — 1 — high in RUN.
- `done` — out — 1 — high in DONE.
- `pass` — out — 1 — (sig == GOLDEN); valid only while `done`, otherwise 0.
- `sig` — out — 16 — current MISR value.

## Operation
States:
- IDLE: after reset.
- IDLE/DONE → RUN: on `start`=1. On that edge: lfsr←SEED, misr←0, cnt←0.
- RUN → DONE: after the edge where cnt reaches N_PAT-1.
- DONE holds until the next `start`.
- `start` while in RUN is ignored; the run is not restarted.

LFSR (Fibonacci, x^10+x^7+1, maximal length):
- fb = lfsr[9] ^ lfsr[6]
- next = {lfsr[8:0], fb}
- Advances only on RUN edges; holds otherwise.

MISR (16-bit, CCITT polynomial 0x1021):
- next = {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 16'h0) ^ {13'b0, y_in}
- Updates only on RUN edges, sampling `y_in` for the pattern currently on `a_out`/`b_out`.

Counter and outputs:
- cnt is 10 bits and increments on each RUN edge.
- `a_out`/`b_out` come from registers, never from combinational logic, so `y_in` is settled within the same cycle.
- In IDLE/DONE, `a_out`/`b_out` hold the last applied pattern.

Reset (any time, including mid-run):
- State←IDLE, lfsr←SEED, misr←0, cnt←0.
- Resulting outputs: `a_out`=SEED[4:0], `b_out`=SEED[9:5], `busy`=0, `done`=0, `pass`=0, `sig`=0.
- `rst` has priority over `start` on the same edge.

## Timing
- `start` sampled at edge E0.
- Pattern k (k=0..N_PAT-1) is on `a_out`/`b_out` during the cycle after edge E0+k.
- Its `y_in` is compacted at edge E0+k+1.
- `busy` is high from E0 through E0+N_PAT.
- `done` rises at edge E0+N_PAT: exactly N_PAT cycles of `busy`.
- `sig` is final when `done` is first high and stays stable while in DONE.
- `start` in DONE at edge D begins a new run at D with the same timing; `done` drops at D.
- Zero-wait combinational loopback is required: no extra response latency is modelled.

## Structure
- Package `eco_bist_pkg`:
  - state enum {IDLE, RUN, DONE}
  - LFSR tap constant (bits 9,6)
  - MISR polynomial 16'h1021
  - widths: A/B = 5, Y = 3, SIG = 16
- Sub-module `eco_misr16`: MISR register with enable and clear. The LFSR, counter and FSM stay in the top level.
- Bench instantiates the circuit under test between `a_out`/`b_out` and `y_in`.

## Test plan
- Reset: hold `rst` 2 cycles → `busy`/`done`/`pass`=0, `sig`=16'h0000, `a_out`=5'h01, `b_out`=5'h00.
- Pattern sequence: SEED=10'h001, `start` one cycle → `a_out` steps 01,02,04,08,10; then `b_out` steps 01,02,… in successive cycles; after 1023 patterns every nonzero 10-bit value has appeared exactly once.
- Stuck-zero response: `y_in` tied to 0, N_PAT=8, GOLDEN=0 → `done` rises exactly 8 cycles after `start`, `sig`=16'h0000, `pass`=1.
- Single-bit response: `y_in`=3'b001 on pattern 0 only, else 0, N_PAT=3 → `sig`=16'h0004, `pass`=0 with GOLDEN=0.
- Mid-run events: `start` re-pulsed during RUN → `done` timing unchanged; `rst` asserted at pattern 5 → next cycle IDLE with all reset values; subsequent `start` reproduces the full-run signature.
- ECO equivalence: original and ECO'd netlists under test, N_PAT=1023 → identical `sig`; an injected gate change (e.g. AND→NAND) → differing `sig` and `pass`=0.

Source files
------------

// File: rtl/eco_bist_pkg.sv
// Shared types and constants for the ECO self-test controller.
// Latency: n/a (definitions only); backpressure: n/a.
package eco_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int AB_W   = 5;
  localparam int Y_W    = 3;
  localparam int SIG_W  = 16;
  localparam int LFSR_W = 2 * AB_W;
  localparam int CNT_W  = 10;

  // x^10 + x^7 + 1 taps, expressed as register bit positions
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], l[LFSR_TAP_HI] ^ l[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/eco_misr16.sv
// 16-bit CCITT MISR compacting the circuit response; one-cycle update latency.
// Backpressure: none; clr wins over en, rst wins over both.
module eco_misr16 import eco_bist_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [Y_W-1:0]   y,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0}
           ^ (sig[SIG_W-1] ? MISR_POLY : '0)
           ^ {{(SIG_W-Y_W){1'b0}}, y};
    end
  end

endmodule

// File: rtl/eco_bist_ctrl.sv
// LFSR-driven BIST for a 5+5 -> 3 combinational ECO circuit, MISR signature vs GOLDEN.
// Latency: N_PAT cycles of busy per run; backpressure: none, start ignored while busy.
module eco_bist_ctrl import eco_bist_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED   = 10'h001,
  parameter int                N_PAT  = 1023,
  parameter logic [SIG_W-1:0]  GOLDEN = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [AB_W-1:0]  a_out,
  output logic [AB_W-1:0]  b_out,
  input  logic [Y_W-1:0]   y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAT - 1);

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  cnt;
  logic              load;
  logic              step;
  logic              last;

  assign last = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final compaction edge leaves the last applied pattern on the outputs.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr <= SEED;
      cnt  <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (!last) lfsr <= lfsr_step(lfsr);
    end
  end

  eco_misr16 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (step),
    .y   (y_in),
    .sig (sig)
  );

  assign a_out = lfsr[AB_W-1:0];
  assign b_out = lfsr[LFSR_W-1:AB_W];
  assign pass  = done && (sig == GOLDEN);

endmodule
